pipe_latch_chain: RTL and testbench

- Parametrised inter-stage pipeline latch; the next generation of the fixed per-stage latches between the datapath stages.
- Carries a WIDTH-bit packed control/data bundle through DEPTH register stages. Each stage has a valid bit and a ready/valid handshake at both ends.
- Supports per-stage flush and optional bubble collapsing, so a stalled downstream stage does not stall upstream stages that are empty.
- Exposes all stage contents to hazard/forwarding logic.

---
 rtl/pipe_latch_chain.sv | 103 ++++++++++
 tb/tb_pipe_latch_chain.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_latch_chain
// Brief    : DEPTH-stage valid/ready pipeline latch with per-stage flush and
//            optional bubble collapsing; all stage contents exposed.
// Revision : 1.0
// ============================================================================
module pipe_latch_chain #(
    parameter int                WIDTH    = 32,
    parameter int                DEPTH    = 2,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0,
    parameter int                COLLAPSE = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [DEPTH-1:0]             flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [DEPTH*WIDTH-1:0]       stage_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int c_OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]   r_v;
    logic [WIDTH-1:0]   r_data [DEPTH];

    logic [DEPTH-1:0]   w_ev;
    logic [DEPTH-1:0]   w_rdy;
    logic [DEPTH-1:0]   w_inc_v;
    logic [WIDTH-1:0]   w_inc_d [DEPTH];
    logic [c_OCC_W-1:0] w_occ;

    assign w_ev = r_v & ~flush;

    // Ready ripples from the consumer back to the producer within the cycle.
    always_comb begin
        logic l_rdy;
        w_rdy = '0;
        l_rdy = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (COLLAPSE != 0) begin
                l_rdy = !w_ev[i] | l_rdy;
            end else begin
                l_rdy = out_ready | !w_ev[DEPTH-1];
            end
            w_rdy[i] = l_rdy;
        end
    end

    always_comb begin
        w_inc_v    = '0;
        w_inc_v[0] = in_valid;
        w_inc_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_inc_v[i] = w_ev[i-1];
            w_inc_d[i] = r_data[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i]    <= w_inc_v[i];
                    r_data[i] <= w_inc_v[i] ? w_inc_d[i] : RST_VAL;
                end else if (flush[i]) begin
                    r_v[i]    <= 1'b0;
                    r_data[i] <= RST_VAL;
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + c_OCC_W'(r_v[i]);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign stage_data[gi*WIDTH +: WIDTH] = r_data[gi];
    end

    assign in_ready    = w_rdy[0];
    assign out_valid   = w_ev[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign stage_valid = w_ev;
    assign occupancy   = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_latch_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_latch_chain
// Brief    : Directed scoreboard bench for pipe_latch_chain across depths and
//            collapse modes.
// Revision : 1.0
// ============================================================================
module tb_pipe_latch_chain;

    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    // a: DEPTH=2 collapse, b1: DEPTH=3 collapse, b0: DEPTH=3 lockstep, c: DEPTH=1
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_flush, a_stage_valid, a_occupancy;
    logic [15:0] a_stage_data;

    logic       b1_in_valid, b1_in_ready, b1_out_valid, b1_out_ready;
    logic [7:0] b1_in_data, b1_out_data;
    logic [2:0] b1_flush, b1_stage_valid;
    logic [1:0] b1_occupancy;
    logic [23:0] b1_stage_data;

    logic       b0_in_valid, b0_in_ready, b0_out_valid, b0_out_ready;
    logic [7:0] b0_in_data, b0_out_data;
    logic [2:0] b0_flush, b0_stage_valid;
    logic [1:0] b0_occupancy;
    logic [23:0] b0_stage_data;

    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0] c_in_data, c_out_data;
    logic [0:0] c_flush, c_stage_valid, c_occupancy;
    logic [7:0] c_stage_data;

    logic [7:0] qa[$];
    logic [7:0] qb1[$];
    logic [7:0] qb0[$];
    logic [7:0] qc[$];

    pipe_latch_chain #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h00), .COLLAPSE(1)) u_a (
        .CLK(CLK), .RST(RST), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .stage_valid(a_stage_valid),
        .stage_data(a_stage_data), .occupancy(a_occupancy));

    pipe_latch_chain #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5), .COLLAPSE(1)) u_b1 (
        .CLK(CLK), .RST(RST), .in_valid(b1_in_valid), .in_ready(b1_in_ready),
        .in_data(b1_in_data), .flush(b1_flush), .out_valid(b1_out_valid),
        .out_ready(b1_out_ready), .out_data(b1_out_data), .stage_valid(b1_stage_valid),
        .stage_data(b1_stage_data), .occupancy(b1_occupancy));

    pipe_latch_chain #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5), .COLLAPSE(0)) u_b0 (
        .CLK(CLK), .RST(RST), .in_valid(b0_in_valid), .in_ready(b0_in_ready),
        .in_data(b0_in_data), .flush(b0_flush), .out_valid(b0_out_valid),
        .out_ready(b0_out_ready), .out_data(b0_out_data), .stage_valid(b0_stage_valid),
        .stage_data(b0_stage_data), .occupancy(b0_occupancy));

    pipe_latch_chain #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h5A), .COLLAPSE(1)) u_c (
        .CLK(CLK), .RST(RST), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .stage_valid(c_stage_valid),
        .stage_data(c_stage_data), .occupancy(c_occupancy));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Consumed outputs are matched against the expected-item queues.
    task automatic sample();
        if (!RST) begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 32'(a_out_valid), 32'd0);
                else                chk("a_out_data", 32'(a_out_data), 32'(qa.pop_front()));
            end
            if (b1_out_valid && b1_out_ready) begin
                if (qb1.size() == 0) chk("b1_unexpected_out", 32'(b1_out_valid), 32'd0);
                else                 chk("b1_out_data", 32'(b1_out_data), 32'(qb1.pop_front()));
            end
            if (b0_out_valid && b0_out_ready) begin
                if (qb0.size() == 0) chk("b0_unexpected_out", 32'(b0_out_valid), 32'd0);
                else                 chk("b0_out_data", 32'(b0_out_data), 32'(qb0.pop_front()));
            end
            if (c_out_valid && c_out_ready) begin
                if (qc.size() == 0) chk("c_unexpected_out", 32'(c_out_valid), 32'd0);
                else                chk("c_out_data", 32'(c_out_data), 32'(qc.pop_front()));
            end
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b1;
        a_in_valid = 0;  a_in_data = 0;  a_flush = 0;  a_out_ready = 0;
        b1_in_valid = 0; b1_in_data = 0; b1_flush = 0; b1_out_ready = 0;
        b0_in_valid = 0; b0_in_data = 0; b0_flush = 0; b0_out_ready = 0;
        c_in_valid = 0;  c_in_data = 0;  c_flush = 0;  c_out_ready = 0;
        cyc();
        cyc();
        RST = 1'b0;
        #1;
        chk("rst_a_occ", 32'(a_occupancy), 32'd0);
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_stage", 32'({a_stage_valid, a_stage_data}), 32'd0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_b1_data", 32'(b1_stage_data), 32'hA5A5A5);
        chk("rst_b0_out_data", 32'(b0_out_data), 32'hA5);
        chk("rst_c_data", 32'({c_occupancy, c_out_data}), 32'h5A);

        // Streaming through DEPTH=2
        a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h11; qa.push_back(8'h11); #1;
        chk("a_in_ready_0", 32'(a_in_ready), 32'd1);
        cyc();
        chk("a_latency_1", 32'(a_out_valid), 32'd0);
        chk("a_occ_1", 32'(a_occupancy), 32'd1);
        a_in_data = 8'h22; qa.push_back(8'h22);
        cyc();
        chk("a_out_valid_2", 32'(a_out_valid), 32'd1);
        chk("a_occ_2", 32'(a_occupancy), 32'd2);
        a_in_data = 8'h33; qa.push_back(8'h33); #1;
        chk("a_in_ready_2", 32'(a_in_ready), 32'd1);
        cyc();
        a_in_valid = 0;
        cyc();
        cyc();
        chk("a_drain_occ", 32'(a_occupancy), 32'd0);
        chk("a_drain_valid", 32'(a_out_valid), 32'd0);

        // Flush of the output stage while a new item enters
        a_in_valid = 1; a_in_data = 8'h44;
        cyc();
        a_in_data = 8'h55;
        cyc();
        chk("a_full_occ", 32'(a_occupancy), 32'd2);
        a_flush = 2'b10; a_in_data = 8'h66; qa.push_back(8'h55); qa.push_back(8'h66); #1;
        chk("a_flush_out_valid", 32'(a_out_valid), 32'd0);
        chk("a_flush_stage_valid", 32'(a_stage_valid), 32'b01);
        chk("a_flush_occ_preflush", 32'(a_occupancy), 32'd2);
        chk("a_flush_in_ready", 32'(a_in_ready), 32'd1);
        cyc();
        a_flush = 0; a_in_valid = 0; #1;
        chk("a_postflush_occ", 32'(a_occupancy), 32'd2);
        chk("a_postflush_data", 32'(a_stage_data), 32'h5566);
        cyc();
        cyc();
        chk("a_postflush_drain", 32'(a_occupancy), 32'd0);

        // All-ones flush with a new item keeps only the new item
        a_in_valid = 1; a_in_data = 8'h88;
        cyc();
        a_in_data = 8'h99;
        cyc();
        a_flush = 2'b11; a_in_data = 8'h77; qa.push_back(8'h77); #1;
        chk("a_flushall_valid", 32'({a_out_valid, a_stage_valid}), 32'd0);
        cyc();
        a_flush = 0; a_in_valid = 0; #1;
        chk("a_flushall_stage_valid", 32'(a_stage_valid), 32'b01);
        chk("a_flushall_data", 32'(a_stage_data), 32'h0077);
        chk("a_flushall_occ", 32'(a_occupancy), 32'd1);
        cyc();
        cyc();

        // Mid-stream reset discards everything, including the presented item
        a_in_valid = 1; a_in_data = 8'h12;
        cyc();
        a_in_data = 8'h34;
        cyc();
        RST = 1; a_in_data = 8'h56;
        cyc();
        RST = 0; a_in_valid = 0; #1;
        chk("a_midrst_occ", 32'(a_occupancy), 32'd0);
        chk("a_midrst_valid", 32'({a_out_valid, a_stage_valid}), 32'd0);
        chk("a_midrst_data", 32'(a_stage_data), 32'd0);
        cyc();
        cyc();

        // COLLAPSE=1, DEPTH=3: later items fill in behind a stalled head
        b1_in_valid = 1; b1_in_data = 8'hAA; qb1.push_back(8'hAA); #1;
        chk("b1_in_ready_a", 32'(b1_in_ready), 32'd1);
        cyc();
        b1_in_valid = 0;
        cyc();
        cyc();
        chk("b1_head_stage_valid", 32'(b1_stage_valid), 32'b100);
        chk("b1_head_out", 32'({b1_out_valid, b1_out_data}), 32'h1AA);
        chk("b1_head_occ", 32'(b1_occupancy), 32'd1);
        b1_in_valid = 1; b1_in_data = 8'hBB; qb1.push_back(8'hBB); #1;
        chk("b1_in_ready_b", 32'(b1_in_ready), 32'd1);
        cyc();
        chk("b1_bubble_data", 32'(b1_stage_data), 32'hAAA5BB);
        b1_in_data = 8'hCC; qb1.push_back(8'hCC); #1;
        chk("b1_in_ready_c", 32'(b1_in_ready), 32'd1);
        cyc();
        b1_in_valid = 0; #1;
        chk("b1_full_stage_valid", 32'(b1_stage_valid), 32'b111);
        chk("b1_full_occ", 32'(b1_occupancy), 32'd3);
        chk("b1_full_in_ready", 32'(b1_in_ready), 32'd0);
        chk("b1_full_data", 32'(b1_stage_data), 32'hAABBCC);
        cyc();
        chk("b1_hold_stage_valid", 32'(b1_stage_valid), 32'b111);
        b1_out_ready = 1; #1;
        chk("b1_release_in_ready", 32'(b1_in_ready), 32'd1);
        cyc();
        cyc();
        cyc();
        chk("b1_drain_occ", 32'(b1_occupancy), 32'd0);
        chk("b1_drain_data", 32'(b1_stage_data), 32'hA5A5A5);

        // COLLAPSE=0, DEPTH=3: lockstep stall keeps the bubble in place
        b0_in_valid = 1; b0_in_data = 8'hAA; qb0.push_back(8'hAA); #1;
        chk("b0_in_ready_a", 32'(b0_in_ready), 32'd1);
        cyc();
        b0_in_valid = 0;
        cyc();
        b0_in_valid = 1; b0_in_data = 8'hBB; qb0.push_back(8'hBB); #1;
        chk("b0_in_ready_b", 32'(b0_in_ready), 32'd1);
        cyc();
        b0_in_data = 8'hCC; #1;
        chk("b0_stall_in_ready", 32'(b0_in_ready), 32'd0);
        chk("b0_stall_stage_valid", 32'(b0_stage_valid), 32'b101);
        cyc();
        chk("b0_hold1_stage_valid", 32'(b0_stage_valid), 32'b101);
        chk("b0_hold1_data", 32'(b0_stage_data), 32'hAAA5BB);
        chk("b0_hold1_occ", 32'(b0_occupancy), 32'd2);
        cyc();
        chk("b0_hold2", 32'({b0_stage_valid, b0_in_ready}), 32'b1010);
        b0_out_ready = 1; qb0.push_back(8'hCC); #1;
        chk("b0_release_in_ready", 32'(b0_in_ready), 32'd1);
        cyc();
        b0_in_valid = 0; #1;
        chk("b0_shift_stage_valid", 32'(b0_stage_valid), 32'b011);
        cyc();
        cyc();
        cyc();
        chk("b0_drain_occ", 32'(b0_occupancy), 32'd0);

        // DEPTH=1 with accept/consume each cycle and alternating flush
        c_out_ready = 1; c_in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            c_in_data = 8'(16 + k);
            c_flush   = 1'(k % 2);
            if ((k % 2) == 1) qc.push_back(c_in_data);
            #1;
            chk("c_out_valid", 32'(c_out_valid), 32'((k >= 2) && ((k % 2) == 0)));
            chk("c_in_ready", 32'(c_in_ready), 32'd1);
            cyc();
        end
        c_in_valid = 0; c_flush = 0;
        cyc();
        chk("c_drain_occ", 32'(c_occupancy), 32'd0);

        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb1_empty", 32'(qb1.size()), 32'd0);
        chk("qb0_empty", 32'(qb0.size()), 32'd0);
        chk("qc_empty", 32'(qc.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
